mesh_phase_ctrl: RTL and testbench
==================================

# mesh_phase_ctrl

Central sequencer for the N-PE sorting mesh. One `start` launches an operation through a fixed series of global phases: load, sort, route, commit. During the sort phase the block drives per-cycle step control (odd/even transposition select, row/column pass select) to every PE. It signals completion with a one-cycle `done` pulse. It replaces the free-running internal sort-cycle counting in the PEs with a single controlled schedule that can be held.

## Interface
Parameters:
- `N`, 64: number of PEs in the mesh; informational, must be a perfect square.
- `SIDE_STEPS`, 8: sort steps per row/column pass (mesh side length).
- `SORT_CYCLES`, 53: cycles spent in SORT phase; must be ≥ 1.
- `ROUTE_CYCLES`, 16: cycles spent in ROUTE phase; must be ≥ 1.
- `CNT_WIDTH`, 8: step counter width; must hold max(SORT_CYCLES, ROUTE_CYCLES) − 1.

Ports:
- `clk`, in, 1: clock; all state changes on rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: request an operation; sampled only in IDLE.
- `hold`, in, 1: freeze SORT/ROUTE progress while high.
- `busy`, out, 1: high in every phase except IDLE.
- `phase`, out, 3: IDLE=0, LOAD=1, SORT=2, ROUTE=3, COMMIT=4, DONE=5.
- `step`, out, CNT_WIDTH: cycle index within current SORT/ROUTE phase; 0 elsewhere.
- `load_en`, out, 1: PEs capture initial key/data (LOAD only).
- `pe_en`, out, 1: PEs perform one compare-exchange/route step this cycle.
- `sort_odd`, out, 1: in SORT, `step[0]`; selects odd vs even transposition pairs.
- `sort_col`, out, 1: in SORT, bit 0 of (`step` / SIDE_STEPS); 0 = row pass, 1 = column pass.
- `write_en`, out, 1: PEs commit routed data to local memory (COMMIT only).
- `done`, out, 1: one-cycle completion pulse (DONE only).

## Operation
- State machine: IDLE → LOAD → SORT → ROUTE → COMMIT → DONE → IDLE.
- IDLE: `start`=1 moves to LOAD next cycle. `start` outside IDLE is ignored and is not queued.
- LOAD: lasts exactly 1 cycle, with `load_en`=1. Then goes to SORT with `step`=0.
- SORT: `pe_en` = ~`hold`. The counter increments only when `hold`=0.
  - When `step`==SORT_CYCLES−1 and `hold`=0: go to ROUTE and reset `step` to 0.
- ROUTE: same hold/count rule. Exits when `step`==ROUTE_CYCLES−1 and `hold`=0.
  - `sort_odd` and `sort_col` are 0 in ROUTE.
- COMMIT: 1 cycle, with `write_en`=1. `hold` is ignored.
- DONE: 1 cycle, with `done`=1. Then returns to IDLE. `start` in this cycle is ignored.
- Outside SORT/ROUTE: `step`, `pe_en`, `sort_odd` and `sort_col` are 0.
- `hold` has no effect in IDLE, LOAD, COMMIT or DONE.
- Counter arithmetic is unsigned and never wraps past the phase limit. The comparison uses the full CNT_WIDTH.
- All outputs are registered or decoded from registered state. There are no combinational paths from `start` or `hold` to outputs, except `pe_en`, which is ~`hold` gated by phase.
- Reset asserted at any time, including mid-SORT:
  - State goes to IDLE immediately (asynchronous) and the counter clears.
  - Every output reads 0: `phase`=0, `busy`=0, `step`=0, all enables 0, `done`=0.
  - Operation resumes only on a new `start` after `rst` is deasserted.

## Timing
- `start` is sampled high in IDLE at edge t. Then:
  - LOAD is visible in cycle t+1.
  - SORT runs in cycles t+2 … t+1+SORT_CYCLES.
  - ROUTE runs in cycles t+2+SORT_CYCLES … t+1+SORT_CYCLES+ROUTE_CYCLES.
  - COMMIT is at t+2+SORT_CYCLES+ROUTE_CYCLES.
  - DONE is at t+3+SORT_CYCLES+ROUTE_CYCLES.
- Default parameters with no hold: `done` is seen 72 cycles after `start`. `busy` is high for 72 cycles.
- Each cycle with `hold`=1 during SORT/ROUTE extends latency by exactly 1 cycle.
- Back-to-back operations: the earliest next `start` acceptance is the IDLE cycle after DONE.
- `pe_en` is asserted exactly SORT_CYCLES times in SORT and ROUTE_CYCLES times in ROUTE, regardless of hold pattern.

## Test plan
- Reset then idle: hold `rst`=1 for 2 cycles, release. Require all outputs 0, `phase`=0, and no activity for 10 cycles without `start`.
- Nominal run, defaults: pulse `start` one cycle.
  - Require `load_en` for 1 cycle and `pe_en` high for 53 cycles with `step` 0..52.
  - Then `pe_en` high for 16 cycles with `step` 0..15, then `write_en` for 1 cycle.
  - `done` must pulse exactly 72 cycles after `start`.
- Sort pass control: during SORT check `sort_odd`=`step[0]`. Check `sort_col`=0 for steps 0–7, 1 for 8–15, 0 for 16–23, …, and 0 at step 48.
- Hold: assert `hold` for 5 cycles at SORT step 10 and 3 cycles at ROUTE step 0.
  - `step` and `pe_en` must freeze.
  - `done` must arrive at cycle 80.
  - Total `pe_en` count must be 69.
- Start while busy and in DONE: pulse `start` at SORT step 20 and again in the DONE cycle. Require a single operation and a return to IDLE with `busy`=0.
- Reset mid-operation: assert `rst` asynchronously (between edges) at ROUTE step 5.
  - Outputs must go to 0 before the next edge.
  - After release, a new `start` must produce a full 72-cycle run.

Source files
------------

// File: rtl/mesh_phase_ctrl.sv
// Global phase sequencer for the sorting mesh: LOAD -> SORT -> ROUTE -> COMMIT -> DONE,
// with a holdable step counter that drives per-cycle PE step control during SORT/ROUTE.
module mesh_phase_ctrl #(
  parameter int N            = 64,
  parameter int SIDE_STEPS   = 8,
  parameter int SORT_CYCLES  = 53,
  parameter int ROUTE_CYCLES = 16,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 hold,
  output logic                 busy,
  output logic [2:0]           phase,
  output logic [CNT_WIDTH-1:0] step,
  output logic                 load_en,
  output logic                 pe_en,
  output logic                 sort_odd,
  output logic                 sort_col,
  output logic                 write_en,
  output logic                 done
);

  // state    | meaning
  // S_IDLE   | waiting for start
  // S_LOAD   | PEs capture initial key/data (1 cycle)
  // S_SORT   | SORT_CYCLES compare-exchange steps, holdable
  // S_ROUTE  | ROUTE_CYCLES routing steps, holdable
  // S_COMMIT | PEs write routed data to local memory (1 cycle)
  // S_DONE   | completion pulse (1 cycle)
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SORT   = 3'd2,
    S_ROUTE  = 3'd3,
    S_COMMIT = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [CNT_WIDTH-1:0] SORT_LAST  = CNT_WIDTH'(SORT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] ROUTE_LAST = CNT_WIDTH'(ROUTE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] SIDE       = CNT_WIDTH'(SIDE_STEPS);

  if (SIDE_STEPS * SIDE_STEPS != N || SORT_CYCLES < 1 || ROUTE_CYCLES < 1) begin : g_bad_params
    $error("mesh_phase_ctrl: inconsistent parameters");
  end

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] pass_idx;
  logic                 in_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (start) state <= S_LOAD;
        end
        S_LOAD: begin
          cnt   <= '0;
          state <= S_SORT;
        end
        S_SORT: begin
          if (!hold) begin
            if (cnt == SORT_LAST) begin
              cnt   <= '0;
              state <= S_ROUTE;
            end else begin
              cnt <= cnt + CNT_WIDTH'(1);
            end
          end
        end
        S_ROUTE: begin
          if (!hold) begin
            if (cnt == ROUTE_LAST) begin
              cnt   <= '0;
              state <= S_COMMIT;
            end else begin
              cnt <= cnt + CNT_WIDTH'(1);
            end
          end
        end
        S_COMMIT: begin
          cnt   <= '0;
          state <= S_DONE;
        end
        S_DONE: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Everything below decodes registered state; only pe_en sees hold directly.
  assign in_count = (state == S_SORT) || (state == S_ROUTE);
  assign pass_idx = cnt / SIDE;

  assign phase    = state;
  assign busy     = (state != S_IDLE);
  assign step     = in_count ? cnt : '0;
  assign load_en  = (state == S_LOAD);
  assign pe_en    = in_count & ~hold;
  assign sort_odd = (state == S_SORT) & cnt[0];
  assign sort_col = (state == S_SORT) & pass_idx[0];
  assign write_en = (state == S_COMMIT);
  assign done     = (state == S_DONE);

endmodule

// File: tb/tb_mesh_phase_ctrl.sv
// Scoreboard bench for mesh_phase_ctrl: stimulus pushes per-cycle expected outputs and
// per-run latency/pe_en totals; a monitor pops and compares on every falling edge.
module tb_mesh_phase_ctrl;

  localparam int SORT_C  = 53;
  localparam int ROUTE_C = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       hold = 1'b0;
  logic       busy, load_en, pe_en, sort_odd, sort_col, write_en, done;
  logic [2:0] phase;
  logic [7:0] step;

  mesh_phase_ctrl #(
    .N(64), .SIDE_STEPS(8), .SORT_CYCLES(SORT_C), .ROUTE_CYCLES(ROUTE_C), .CNT_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .busy(busy), .phase(phase),
    .step(step), .load_en(load_en), .pe_en(pe_en), .sort_odd(sort_odd),
    .sort_col(sort_col), .write_en(write_en), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] phase;
    logic       busy;
    logic [7:0] step;
    logic       load_en;
    logic       pe_en;
    logic       sort_odd;
    logic       sort_col;
    logic       write_en;
    logic       done;
  } rec_t;

  typedef struct packed {
    int latency;
    int pe_count;
  } res_t;

  rec_t exp_q[$];
  res_t res_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc_cnt  = 0;
  int   t_start  = 0;
  int   pe_cnt   = 0;
  string tag = "reset";

  function automatic rec_t mk(int ph, int st, bit ld, bit pe, bit wr, bit dn);
    rec_t r;
    r.phase    = 3'(ph);
    r.busy     = (ph != 0);
    r.step     = 8'(st);
    r.load_en  = ld;
    r.pe_en    = pe;
    r.sort_odd = (ph == 2) && (st % 2 == 1);
    r.sort_col = (ph == 2) && ((st / 8) % 2 == 1);
    r.write_en = wr;
    r.done     = dn;
    return r;
  endfunction

  rec_t z;
  initial z = mk(0, 0, 0, 0, 0, 0);

  task automatic cyc(input logic r, input logic s, input logic h, input rec_t e);
    @(posedge clk);
    #1;
    rst = r;
    start = s;
    hold = h;
    exp_q.push_back(e);
  endtask

  // One operation built from the documented timeline. Negative *_at arguments disable
  // the corresponding feature; rst_route_at aborts the run with an async reset.
  task automatic run_op(input int hs_at, input int hs_len, input int hr_at, input int hr_len,
                        input bit hold_other, input int start_sort_at, input bit start_in_done,
                        input int rst_route_at);
    if (rst_route_at < 0)
      res_q.push_back('{latency: 72 + hs_len + hr_len, pe_count: SORT_C + ROUTE_C});
    cyc(0, 1, hold_other, z);
    cyc(0, 0, hold_other, mk(1, 0, 1, 0, 0, 0));
    for (int s = 0; s < SORT_C; s++) begin
      if (s == hs_at)
        for (int k = 0; k < hs_len; k++) cyc(0, 0, 1, mk(2, s, 0, 0, 0, 0));
      cyc(0, (s == start_sort_at), 0, mk(2, s, 0, 1, 0, 0));
    end
    for (int s = 0; s < ROUTE_C; s++) begin
      if (s == rst_route_at) begin
        @(posedge clk);
        #1;
        start = 1'b0;
        hold = 1'b0;
        #2;
        rst = 1'b1;
        exp_q.push_back(z);
        cyc(1, 0, 0, z);
        cyc(0, 0, 0, z);
        return;
      end
      if (s == hr_at)
        for (int k = 0; k < hr_len; k++) cyc(0, 0, 1, mk(3, s, 0, 0, 0, 0));
      cyc(0, 0, 0, mk(3, s, 0, 1, 0, 0));
    end
    cyc(0, 0, hold_other, mk(4, 0, 0, 0, 1, 0));
    cyc(0, start_in_done, hold_other, mk(5, 0, 0, 0, 0, 1));
    for (int k = 0; k < 3; k++) cyc(0, 0, hold_other, z);
  endtask

  // Monitor: one expected record per falling edge, plus per-run totals on done.
  always @(negedge clk) begin
    rec_t act;
    res_t er;
    cyc_cnt++;
    act = '{phase, busy, step, load_en, pe_en, sort_odd, sort_col, write_en, done};
    if (exp_q.size() > 0) begin
      rec_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s cycle %0d: outputs got %h expected %h (ph=%0d step=%0d)",
                 tag, cyc_cnt, act, e, phase, step);
      end
    end
    if (pe_en === 1'b1) pe_cnt++;
    if (done === 1'b1) begin
      n_checks++;
      if (res_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s unexpected_done: got done=1 required no done", tag);
      end else begin
        er = res_q.pop_front();
        if (cyc_cnt - t_start != er.latency) begin
          n_fail++;
          $display("FAIL %s done_latency: got %0d required %0d", tag, cyc_cnt - t_start, er.latency);
        end
        n_checks++;
        if (pe_cnt != er.pe_count) begin
          n_fail++;
          $display("FAIL %s pe_en_count: got %0d required %0d", tag, pe_cnt, er.pe_count);
        end
      end
    end
    if (start === 1'b1 && rst === 1'b0 && phase === 3'd0) begin
      t_start = cyc_cnt;
      pe_cnt  = 0;
    end
  end

  initial begin
    tag = "reset_idle";
    cyc(1, 0, 0, z);
    cyc(1, 0, 0, z);
    for (int k = 0; k < 10; k++) cyc(0, 0, (k % 2 == 1), z);

    tag = "nominal";
    run_op(-1, 0, -1, 0, 0, -1, 0, -1);

    tag = "hold";
    run_op(10, 5, 0, 3, 1, -1, 0, -1);

    tag = "start_busy";
    run_op(-1, 0, -1, 0, 0, 20, 1, -1);

    tag = "reset_mid";
    run_op(-1, 0, -1, 0, 0, -1, 0, 5);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, z);

    tag = "after_reset";
    run_op(-1, 0, -1, 0, 0, -1, 0, -1);

    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0 || res_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d records and %0d runs pending, required 0 and 0",
               exp_q.size(), res_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
